dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single data memory (`dmem`: combinational read, write on rising `clk`) between two requesters. Port 0 is the processor datapath; port 1 is a secondary master such as a program loader or debug/DMA engine. Grant is combinational, so an uncontended access completes in one cycle. Sequential state holds a round-robin priority pointer, a burst lock owner and a burst counter. A misaligned-address guard prevents corrupting writes.

---
 rtl/dmem_arbiter.sv | 118 +++++++++++
 tb/tb_dmem_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter with locked bursts for one shared data memory.
// Revision 1.0
`default_nettype none

module dmem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_req,
  input  logic          p1_req,
  input  logic          p0_we,
  input  logic          p1_we,
  input  logic          p0_lock,
  input  logic          p1_lock,
  input  logic [AW-1:0] p0_addr,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p0_wdata,
  input  logic [DW-1:0] p1_wdata,
  output logic          p0_ack,
  output logic          p1_ack,
  output logic [DW-1:0] p0_rdata,
  output logic [DW-1:0] p1_rdata,
  output logic          p0_err,
  output logic          p1_err,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  localparam logic [4:0] C_MAX = 5'(MAX_BURST);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_t;

  owner_t        r_owner, w_owner_nxt;
  logic          r_prio, w_prio_nxt;
  logic [3:0]    r_bcnt, w_bcnt_nxt;

  logic          w_gnt0, w_gnt1, w_any;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;
  logic          w_sel_we, w_sel_lock, w_misal;
  logic [3:0]    w_base;
  logic [4:0]    w_inc;

  // An owner that drops its request loses the lock in the same cycle.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!reset) begin
      if (r_owner == OWN_P0 && p0_req)      w_gnt0 = 1'b1;
      else if (r_owner == OWN_P1 && p1_req) w_gnt1 = 1'b1;
      else if (p0_req && p1_req) begin
        if (r_prio) w_gnt1 = 1'b1;
        else        w_gnt0 = 1'b1;
      end
      else if (p0_req) w_gnt0 = 1'b1;
      else if (p1_req) w_gnt1 = 1'b1;
    end
  end

  assign w_any       = w_gnt0 | w_gnt1;
  assign w_sel_addr  = w_gnt1 ? p1_addr  : p0_addr;
  assign w_sel_wdata = w_gnt1 ? p1_wdata : p0_wdata;
  assign w_sel_we    = w_gnt1 ? p1_we    : p0_we;
  assign w_sel_lock  = w_gnt1 ? p1_lock  : p0_lock;
  assign w_misal     = |w_sel_addr[1:0];

  assign mem_a    = w_any ? w_sel_addr  : '0;
  assign mem_wd   = w_any ? w_sel_wdata : '0;
  assign mem_we   = w_any & w_sel_we & ~w_misal;

  assign p0_ack   = w_gnt0;
  assign p1_ack   = w_gnt1;
  assign p0_err   = w_gnt0 & w_misal;
  assign p1_err   = w_gnt1 & w_misal;
  assign p0_rdata = (w_gnt0 && !w_misal) ? mem_rd : '0;
  assign p1_rdata = (w_gnt1 && !w_misal) ? mem_rd : '0;

  // Burst count continues only when the current owner is the one granted.
  assign w_base = ((w_gnt0 && r_owner == OWN_P0) || (w_gnt1 && r_owner == OWN_P1)) ? r_bcnt : 4'd0;
  assign w_inc  = {1'b0, w_base} + 5'd1;

  always_comb begin
    w_prio_nxt  = r_prio;
    w_owner_nxt = OWN_NONE;
    w_bcnt_nxt  = 4'd0;
    if (w_any) begin
      w_prio_nxt = w_gnt0;
      if (w_sel_lock && w_inc < C_MAX) begin
        w_owner_nxt = w_gnt0 ? OWN_P0 : OWN_P1;
        w_bcnt_nxt  = w_inc[3:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prio  <= 1'b0;
      r_owner <= OWN_NONE;
      r_bcnt  <= 4'd0;
    end else begin
      r_prio  <= w_prio_nxt;
      r_owner <= w_owner_nxt;
      r_bcnt  <= w_bcnt_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random checks of dmem_arbiter against a transaction-level model.
// Revision 1.0
`default_nettype none

module tb_dmem_arbiter;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req = '0, we = '0, lock = '0;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];

  logic        p0_ack, p1_ack, p0_err, p1_err, mem_we;
  logic [31:0] p0_rdata, p1_rdata, mem_a, mem_wd, mem_rd;

  logic [31:0] dmem [64];
  logic [31:0] ref_mem [64];

  int n_tests = 0, n_fail = 0;
  int m_prio, m_owner, m_cnt, m_g;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(MAXB)) dut (
    .clk(clk), .reset(reset),
    .p0_req(req[0]), .p1_req(req[1]),
    .p0_we(we[0]), .p1_we(we[1]),
    .p0_lock(lock[0]), .p1_lock(lock[1]),
    .p0_addr(addr[0]), .p1_addr(addr[1]),
    .p0_wdata(wdata[0]), .p1_wdata(wdata[1]),
    .p0_ack(p0_ack), .p1_ack(p1_ack),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .p0_err(p0_err), .p1_err(p1_err),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Shared data memory: combinational read, write on the rising edge.
  assign mem_rd = dmem[mem_a[7:2]];
  always @(posedge clk) if (mem_we) dmem[mem_a[7:2]] <= mem_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  function automatic int exp_grant();
    if (reset) return -1;
    if (m_owner >= 0 && req[m_owner]) return m_owner;
    if (req[0] && req[1]) return m_prio;
    if (req[0]) return 0;
    if (req[1]) return 1;
    return -1;
  endfunction

  task automatic set_p(input int p, input logic r, input logic w, input logic l,
                       input logic [31:0] a, input logic [31:0] d);
    req[p] = r; we[p] = w; lock[p] = l; addr[p] = a; wdata[p] = d;
  endtask

  // Called at posedge+1; samples at the falling edge and compares every output.
  task automatic check_cycle();
    int gi;
    logic mis;
    #4;
    m_g = exp_grant();
    gi  = (m_g < 0) ? 0 : m_g;
    mis = (m_g >= 0) && (addr[gi][1:0] != 2'b00);
    chk1("p0_ack", p0_ack, m_g == 0);
    chk1("p1_ack", p1_ack, m_g == 1);
    chk1("p0_err", p0_err, m_g == 0 && mis);
    chk1("p1_err", p1_err, m_g == 1 && mis);
    chk1("mem_we", mem_we, m_g >= 0 && we[gi] && !mis);
    chk("mem_a",  mem_a,  (m_g >= 0) ? addr[gi]  : 32'h0);
    chk("mem_wd", mem_wd, (m_g >= 0) ? wdata[gi] : 32'h0);
    chk("p0_rdata", p0_rdata, (m_g == 0 && !mis) ? ref_mem[addr[0][7:2]] : 32'h0);
    chk("p1_rdata", p1_rdata, (m_g == 1 && !mis) ? ref_mem[addr[1][7:2]] : 32'h0);
  endtask

  task automatic finish_cycle();
    int base;
    if (reset) begin
      m_prio = 0; m_owner = -1; m_cnt = 0;
    end else if (m_g >= 0) begin
      base   = (m_owner == m_g) ? m_cnt : 0;
      m_prio = 1 - m_g;
      if (lock[m_g] && base + 1 < MAXB) begin
        m_owner = m_g; m_cnt = base + 1;
      end else begin
        m_owner = -1; m_cnt = 0;
      end
      if (we[m_g] && addr[m_g][1:0] == 2'b00) ref_mem[addr[m_g][7:2]] = wdata[m_g];
    end else begin
      m_owner = -1; m_cnt = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    check_cycle();
    finish_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, g, last_g;
    logic p0done;
    int seen[$];
    int exp_seq[7] = '{1, 1, 1, 1, 0, 1, 1};

    for (int i = 0; i < 64; i++) begin dmem[i] = '0; ref_mem[i] = '0; end
    m_prio = 0; m_owner = -1; m_cnt = 0; m_g = -1;
    set_p(0, 0, 0, 0, 0, 0);
    set_p(1, 0, 0, 0, 0, 0);
    #1;

    // Reset with requests pending: nothing may be granted.
    set_p(0, 1, 1, 0, 32'h8, 32'h11);
    step(); step();
    reset = 1'b0;

    // Contention with reads, lock low: strict alternation from p0.
    set_p(0, 1, 0, 0, 32'h0, 0);
    set_p(1, 1, 0, 0, 32'h4, 0);
    check_cycle(); chk1("cont_first_p0", p0_ack, 1'b1); finish_cycle();
    repeat (3) step();

    // Simultaneous writes, then readback.
    set_p(0, 1, 1, 0, 32'h0, 32'd100);
    set_p(1, 1, 1, 0, 32'h4, 32'd200);
    check_cycle(); chk1("wr_c1_p0", p0_ack, 1'b1); finish_cycle();
    set_p(0, 0, 0, 0, 0, 0);
    check_cycle(); chk1("wr_c2_p1", p1_ack, 1'b1); finish_cycle();
    set_p(0, 1, 0, 0, 32'h0, 0);
    set_p(1, 1, 0, 0, 32'h4, 0);
    check_cycle(); chk("rb_p0", p0_rdata, 32'd100); finish_cycle();
    set_p(0, 0, 0, 0, 0, 0);
    check_cycle(); chk("rb_p1", p1_rdata, 32'd200); finish_cycle();
    set_p(1, 0, 0, 0, 0, 0);

    // Burst limit: p1 locked writes 1..6, p0 joins from the second transfer.
    k = 1; p0done = 1'b0;
    set_p(1, 1, 1, 1, 32'h0, 32'd1);
    for (int c = 0; c < 20 && k <= 6; c++) begin
      if (k >= 2 && !p0done) set_p(0, 1, 0, 0, 32'h40, 0);
      check_cycle();
      seen.push_back(p1_ack ? 1 : (p0_ack ? 0 : -1));
      g = m_g;
      finish_cycle();
      if (g == 1) begin
        k++;
        if (k <= 6) set_p(1, 1, 1, 1, 32'((k - 1) * 4), 32'(k));
        else        set_p(1, 0, 0, 0, 0, 0);
      end
      if (g == 0) begin
        p0done = 1'b1;
        set_p(0, 0, 0, 0, 0, 0);
      end
    end
    chk("burst_len", 32'(seen.size()), 32'd7);
    for (int i = 0; i < 7; i++)
      chk("burst_seq", (i < seen.size()) ? 32'(seen[i]) : 32'hFFFF_FFFF, 32'(exp_seq[i]));
    for (int i = 0; i < 6; i++) begin
      set_p(0, 1, 0, 0, 32'(i * 4), 0);
      check_cycle(); chk("burst_mem", p0_rdata, 32'(i + 1)); finish_cycle();
    end
    set_p(0, 0, 0, 0, 0, 0);

    // Voluntary release on p0's second transfer.
    set_p(0, 1, 1, 1, 32'h80, 32'h55);
    check_cycle(); chk1("vol_c1_p0", p0_ack, 1'b1); finish_cycle();
    set_p(0, 1, 1, 0, 32'h84, 32'h66);
    set_p(1, 1, 0, 0, 32'h88, 0);
    check_cycle(); chk1("vol_c2_p0", p0_ack, 1'b1); finish_cycle();
    chk("vol_bcnt", {28'b0, dut.r_bcnt}, 32'd0);
    set_p(0, 0, 0, 0, 0, 0);
    check_cycle(); chk1("vol_c3_p1", p1_ack, 1'b1); finish_cycle();
    set_p(1, 0, 0, 0, 0, 0);

    // Misaligned write must not reach memory.
    set_p(0, 1, 1, 0, 32'h4, 32'd400);
    step();
    set_p(0, 1, 1, 0, 32'h6, 32'hDEADBEEF);
    check_cycle();
    chk1("mis_ack", p0_ack, 1'b1);
    chk1("mis_err", p0_err, 1'b1);
    chk1("mis_we", mem_we, 1'b0);
    finish_cycle();
    set_p(0, 1, 0, 0, 32'h4, 0);
    check_cycle(); chk("mis_keep", p0_rdata, 32'd400); finish_cycle();
    set_p(0, 0, 0, 0, 0, 0);

    // Reset in the middle of a p1 burst.
    set_p(1, 1, 1, 1, 32'h90, 32'd7);
    step();
    set_p(1, 1, 1, 1, 32'h94, 32'd8);
    set_p(0, 1, 0, 0, 32'h98, 0);
    step();
    reset = 1'b1;
    check_cycle();
    chk1("rst_p0_ack", p0_ack, 1'b0);
    chk1("rst_p1_ack", p1_ack, 1'b0);
    chk1("rst_we", mem_we, 1'b0);
    finish_cycle();
    reset = 1'b0;
    check_cycle();
    chk1("rst_after_p0", p0_ack, 1'b1);
    chk("rst_owner", {30'b0, dut.r_owner}, 32'd0);
    finish_cycle();
    set_p(0, 0, 0, 0, 0, 0);
    set_p(1, 0, 0, 0, 0, 0);

    // Random traffic; an unacked request is held unchanged.
    last_g = -1;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!(req[p] && last_g != p)) begin
          logic [31:0] a;
          a = {24'b0, 6'($urandom_range(0, 63)), 2'b00};
          if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
          set_p(p, $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 2) != 0,
                a, $urandom);
        end
      end
      reset = ($urandom_range(0, 49) == 0);
      check_cycle();
      last_g = m_g;
      finish_cycle();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
